stepper_phase_driver: RTL and testbench

Converts the `step`/`dir` pulse stream from the scan controller into four coil drive signals for a unipolar/bipolar stepper bridge, sequencing through an 8-entry half-step or 4-entry full-step phase table. It also:
- tracks absolute position;
- rejects steps that arrive too close together (flagging overspeed);
- de-energizes the coils after a configurable idle time to cut holding current.

It sits directly downstream of the scan controller and drives the motor bridge pins.

---
 rtl/stepper_pkg.sv | 29 ++
 rtl/step_interval_timer.sv | 41 ++++
 rtl/stepper_phase_driver.sv | 88 ++++++++
 tb/tb_stepper_phase_driver.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper phase driver: coil phase table, coil bit
// positions and the step direction encoding used by the scan controller.
package stepper_pkg;

    localparam int COIL_A   = 0;
    localparam int COIL_B   = 1;
    localparam int COIL_A_N = 2;
    localparam int COIL_B_N = 3;

    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } dir_e;

    // Half-step sequence; full-step mode uses only the odd (two-coil) entries.
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110,
        4'b0100, 4'b1100, 4'b1000, 4'b1001
    };

    function automatic logic [2:0] next_phase(input logic [2:0] phase,
                                              input dir_e       dir,
                                              input logic       half);
        logic [2:0] delta;
        delta = half ? 3'd1 : 3'd2;
        return (dir == REV) ? phase - delta : phase + delta;
    endfunction

endpackage

// File: rtl/step_interval_timer.sv
// Saturating count of clocks since the last accepted step; answers "may the
// next step be taken" and "will the coils be idle after this edge".
module step_interval_timer #(
    parameter int MIN_STEP_GAP = 10,
    parameter int IDLE_TIMEOUT = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic gap_ok,
    output logic idle
);

    localparam int W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [W-1:0] TIMEOUT_V  = W'(IDLE_TIMEOUT);
    localparam logic [W-1:0] GAP_M1_V   = W'(MIN_STEP_GAP - 1);

    logic [W-1:0] since;
    logic [W-1:0] since_next;

    always_comb begin
        since_next = since;
        if (clear)
            since_next = '0;
        else if (since != TIMEOUT_V)
            since_next = since + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            since <= TIMEOUT_V;
        else
            since <= since_next;
    end

    // since is 0 in the cycle after an accepted step, so a request g cycles
    // later observes g-1; idle looks ahead so registered coils drop on time.
    assign gap_ok = (since >= GAP_M1_V);
    assign idle   = (since_next == TIMEOUT_V);

endmodule

// File: rtl/stepper_phase_driver.sv
// Step/dir to four-coil phase driver with position tracking, step-rate
// rejection and idle de-energize.
module stepper_phase_driver
    import stepper_pkg::*;
#(
    parameter int HALF_STEP    = 1,
    parameter int MIN_STEP_GAP = 10,
    parameter int IDLE_TIMEOUT = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        step,
    input  logic        dir,
    input  logic        clear_fault,
    output logic [3:0]  coils,
    output logic [15:0] position,
    output logic        energized,
    output logic        overspeed
);

    localparam logic       HALF_MODE   = (HALF_STEP != 0);
    localparam logic [2:0] PHASE_RESET = HALF_MODE ? 3'd0 : 3'd1;

    logic        step_q;
    logic [2:0]  phase;
    logic [2:0]  phase_next;
    logic [15:0] position_next;
    logic [3:0]  coils_next;
    logic        drive_next;
    logic        overspeed_next;
    logic        request;
    logic        accept;
    logic        reject;
    logic        gap_ok;
    logic        idle;

    step_interval_timer #(
        .MIN_STEP_GAP (MIN_STEP_GAP),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .gap_ok (gap_ok),
        .idle   (idle)
    );

    always_comb begin
        request        = enable && step && !step_q;
        accept         = request && gap_ok;
        reject         = request && !gap_ok;
        phase_next     = phase;
        position_next  = position;
        if (accept) begin
            phase_next    = next_phase(phase, dir_e'(dir), HALF_MODE);
            position_next = (dir_e'(dir) == REV) ? position - 16'd1 : position + 16'd1;
        end
        drive_next     = enable && !idle;
        coils_next     = drive_next ? PHASE_TABLE[phase_next] : 4'b0000;
        overspeed_next = overspeed;
        if (reject)
            overspeed_next = 1'b1;
        else if (clear_fault)
            overspeed_next = 1'b0;
    end

    // step_q follows step even while disabled, so a step held across enable
    // rising is not mistaken for a new request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q    <= 1'b0;
            phase     <= PHASE_RESET;
            position  <= 16'd0;
            coils     <= 4'b0000;
            energized <= 1'b0;
            overspeed <= 1'b0;
        end else begin
            step_q    <= step;
            phase     <= phase_next;
            position  <= position_next;
            coils     <= coils_next;
            energized <= drive_next;
            overspeed <= overspeed_next;
        end
    end

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Randomized bench for stepper_phase_driver: half-step and full-step instances
// share stimulus and are compared every cycle against a step-history model.
module tb_stepper_phase_driver;

    localparam int GAP     = 10;
    localparam int TIMEOUT = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        step;
    logic        dir;
    logic        clear_fault;
    logic [3:0]  coils_h, coils_f;
    logic [15:0] pos_h, pos_f;
    logic        en_h, en_f, ov_h, ov_f;

    int n_checks = 0;
    int n_errors = 0;

    // model: cycle index of the last accepted request and net step count
    int         now;
    int         last_acc;
    int         net;
    logic       m_prev_step;
    logic       m_ov;
    logic [3:0] table_m [8];

    always #5 clk = ~clk;

    stepper_phase_driver #(.HALF_STEP(1), .MIN_STEP_GAP(GAP), .IDLE_TIMEOUT(TIMEOUT)) u_half (
        .clk(clk), .reset(reset), .enable(enable), .step(step), .dir(dir),
        .clear_fault(clear_fault), .coils(coils_h), .position(pos_h),
        .energized(en_h), .overspeed(ov_h)
    );

    stepper_phase_driver #(.HALF_STEP(0), .MIN_STEP_GAP(GAP), .IDLE_TIMEOUT(TIMEOUT)) u_full (
        .clk(clk), .reset(reset), .enable(enable), .step(step), .dir(dir),
        .clear_fault(clear_fault), .coils(coils_f), .position(pos_f),
        .energized(en_f), .overspeed(ov_f)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, now, obs, exp);
        end
    endtask

    function automatic int mod8(input int x);
        return ((x % 8) + 8) % 8;
    endfunction

    task automatic model_reset();
        net         = 0;
        last_acc    = now - 100000;
        m_prev_step = 1'b0;
        m_ov        = 1'b0;
    endtask

    task automatic check_all();
        logic       live;
        logic [3:0] e_h, e_f;
        live = enable && ((now - last_acc) < TIMEOUT);
        e_h  = live ? table_m[mod8(net)] : 4'b0000;
        e_f  = live ? table_m[mod8(1 + 2 * net)] : 4'b0000;
        check("coils_half", 16'(coils_h), 16'(e_h));
        check("coils_full", 16'(coils_f), 16'(e_f));
        check("pos_half",   pos_h, 16'(net));
        check("pos_full",   pos_f, 16'(net));
        check("energized",  16'({en_h, en_f}), 16'({live, live}));
        check("overspeed",  16'({ov_h, ov_f}), 16'({m_ov, m_ov}));
    endtask

    // One clock: apply inputs, advance the model at the edge, compare after it.
    task automatic cycle(input logic s, input logic d, input logic en, input logic clr);
        logic req, acc;
        step = s; dir = d; enable = en; clear_fault = clr;
        @(posedge clk);
        now++;
        req = en && s && !m_prev_step;
        acc = req && ((now - last_acc) >= GAP);
        if (acc) begin
            last_acc = now;
            net      = d ? net - 1 : net + 1;
        end
        if (req && !acc)
            m_ov = 1'b1;
        else if (clr)
            m_ov = 1'b0;
        m_prev_step = s;
        #1;
        check_all();
    endtask

    task automatic pulse(input logic d, input logic en, input int gap);
        cycle(1'b1, d, en, 1'b0);
        for (int i = 1; i < gap; i++)
            cycle(1'b0, d, en, 1'b0);
    endtask

    initial begin
        table_m[0] = 4'b0001; table_m[1] = 4'b0011; table_m[2] = 4'b0010; table_m[3] = 4'b0110;
        table_m[4] = 4'b0100; table_m[5] = 4'b1100; table_m[6] = 4'b1000; table_m[7] = 4'b1001;
        now = 0;
        reset = 1'b1; enable = 1'b0; step = 1'b0; dir = 1'b0; clear_fault = 1'b0;
        #1;
        check("rst_coils", 16'({coils_h, coils_f}), 16'h0000);
        check("rst_pos",   pos_h, 16'h0000);
        check("rst_flags", 16'({en_h, en_f, ov_h, ov_f}), 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // reset then single forward step
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("first_step_coils", 16'(coils_h), 16'h0003);
        check("first_step_pos",   pos_h, 16'd1);
        for (int i = 1; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // forward wrap through the table then back
        for (int i = 0; i < 8; i++) pulse(1'b0, 1'b1, 20);
        check("fwd_wrap_coils", 16'(coils_h), 16'h0003);
        check("fwd_wrap_pos",   pos_h, 16'd9);
        for (int i = 0; i < 8; i++) pulse(1'b1, 1'b1, 20);

        // gap boundary: 9 apart rejected, 10 apart accepted, then clear
        pulse(1'b0, 1'b1, 9);
        pulse(1'b0, 1'b1, 20);
        check("gap9_overspeed", 16'(ov_h), 16'd1);
        pulse(1'b0, 1'b1, 10);
        pulse(1'b0, 1'b1, 20);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("cleared_overspeed", 16'(ov_h), 16'd0);

        // idle timeout and re-energize at the next phase
        pulse(1'b0, 1'b1, TIMEOUT + 5);
        check("idle_coils", 16'(coils_h), 16'h0000);
        pulse(1'b1, 1'b1, 20);

        // disabled: steps ignored, no overspeed
        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b0, 3);

        // randomized pulse train with held steps and occasional disable/clear
        for (int i = 0; i < 250; i++) begin
            int   gap, hold;
            logic d, en, clr;
            gap  = $urandom_range(1, 25);
            hold = $urandom_range(1, (gap < 3) ? gap : 3);
            d    = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 9) != 0);
            clr  = ($urandom_range(0, 7) == 0);
            cycle(1'b1, d, en, clr);
            for (int k = 1; k < gap; k++)
                cycle((k < hold) ? 1'b1 : 1'b0, d, en, 1'b0);
        end

        // asynchronous reset mid-motion
        pulse(1'b0, 1'b1, 20);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        step = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_coils", 16'({coils_h, coils_f}), 16'h0000);
        check("async_pos",   16'(pos_h | pos_f), 16'h0000);
        check("async_flags", 16'({en_h, en_f, ov_h, ov_f}), 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
